// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV64M multiply/divide sequencer that sits beside the single-cycle
// ALU. One M-extension operation is accepted at a time. A shift-add multiply or
// restoring divide runs for DATA_SIZE iterations on operand magnitudes. Sign
// correction is applied in FIXUP, and the registered result is presented with a
// one-cycle valid strobe.
//
// Ports
//   clk          in   clock, all state changes on rising edge
//   rst_n        in   synchronous active-low reset
//   start        in   operation request, sampled only when not busy
//   op[2:0]      in   RV funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   src1         in   rs1 (multiplicand / dividend)
//   src2         in   rs2 (multiplier / divisor)
//   flush        in   aborts the current operation, wins over start
//   busy         out  high in CALC and FIXUP
//   result_valid out  one-cycle strobe in DONE
//   result       out  registered result, held until replaced
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int DATA_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [DATA_SIZE-1:0] src1,
    input  logic [DATA_SIZE-1:0] src2,
    input  logic                 flush,
    output logic                 busy,
    output logic                 result_valid,
    output logic [DATA_SIZE-1:0] result
);

    localparam int N  = DATA_SIZE;
    localparam int CW = $clog2(DATA_SIZE);
    localparam logic [CW-1:0] CNT_INIT = CW'(DATA_SIZE - 1);
    localparam logic [N-1:0]  MOST_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t         r_state, w_next_state;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_result;
    logic [2:0]     r_op;
    logic [N-1:0]   r_opnd;      // multiplicand magnitude or divisor magnitude
    logic [2*N-1:0] r_acc;       // {hi, lo} product or {rem, quot}
    logic           r_neg_res;   // operand signs differ
    logic           r_neg1;      // dividend negative (remainder sign)

    logic           w_accept;
    logic           w_s1_signed, w_s2_signed, w_neg1, w_neg2;
    logic [N-1:0]   w_mag1, w_mag2;
    logic           w_div0, w_ovf, w_special;
    logic [N-1:0]   w_special_res;
    logic [N:0]     w_mul_sum;
    logic [2*N-1:0] w_mul_next;
    logic [N:0]     w_rem_sh;
    logic [N-1:0]   w_rem_sub;
    logic           w_ge;
    logic [2*N-1:0] w_div_next;
    logic [2*N-1:0] w_prod;
    logic [N-1:0]   w_quot, w_rem, w_fix_res;

    assign busy         = (r_state == CALC) || (r_state == FIXUP);
    assign result_valid = (r_state == DONE);
    assign result       = r_result;

    assign w_accept = start && !flush && ((r_state == IDLE) || (r_state == DONE));

    // MUL keeps both operands unsigned: the low half is sign-agnostic.
    assign w_s1_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    assign w_s2_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    assign w_neg1      = w_s1_signed && src1[N-1];
    assign w_neg2      = w_s2_signed && src2[N-1];
    assign w_mag1      = w_neg1 ? -src1 : src1;
    assign w_mag2      = w_neg2 ? -src2 : src2;

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    assign w_div0    = (src2 == '0);
    assign w_ovf     = ((op == 3'd4) || (op == 3'd6)) && (src1 == MOST_NEG) && (src2 == '1);
    assign w_special = op[2] && (w_div0 || w_ovf);
    assign w_special_res = w_div0 ? (op[1] ? src1 : '1)
                                  : (op[1] ? '0   : src1);

    // Shift-add multiply step: conditional add into the upper half, then shift
    // the carry back in from the top.
    assign w_mul_sum  = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[N-1:1]};

    // Restoring divide step. The shifted remainder needs one extra bit; after a
    // successful subtract it always fits back into N bits.
    assign w_rem_sh   = r_acc[2*N-1:N-1];
    assign w_ge       = (w_rem_sh >= {1'b0, r_opnd});
    assign w_rem_sub  = w_rem_sh[N-1:0] - r_opnd;
    assign w_div_next = w_ge ? {w_rem_sub,        r_acc[N-2:0], 1'b1}
                             : {w_rem_sh[N-1:0],  r_acc[N-2:0], 1'b0};

    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quot = r_neg_res ? -r_acc[N-1:0]   : r_acc[N-1:0];
    assign w_rem  = r_neg1    ? -r_acc[2*N-1:N] : r_acc[2*N-1:N];

    always_comb begin
        w_fix_res = w_prod[N-1:0];
        case (r_op)
            3'd0:                 w_fix_res = w_prod[N-1:0];
            3'd1, 3'd2, 3'd3:     w_fix_res = w_prod[2*N-1:N];
            3'd4, 3'd5:           w_fix_res = w_quot;
            default:              w_fix_res = w_rem;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = IDLE;
            CALC:    if (r_cnt == '0) w_next_state = FIXUP;
            FIXUP:   w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (w_accept)
            w_next_state = w_special ? DONE : CALC;
        if (flush)
            w_next_state = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept)
                r_cnt <= CNT_INIT;
            else if ((r_state == CALC) && (r_cnt != '0))
                r_cnt <= r_cnt - 1'b1;

            if (w_accept && w_special)
                r_result <= w_special_res;
            else if ((r_state == FIXUP) && !flush)
                r_result <= w_fix_res;
        end
    end

    // Datapath registers carry no reset; they are always loaded on accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op      <= op;
            r_neg_res <= w_neg1 ^ w_neg2;
            r_neg1    <= w_neg1;
            if (op[2]) begin
                r_opnd <= w_mag2;
                r_acc  <= {{N{1'b0}}, w_mag1};
            end else begin
                r_opnd <= w_mag1;
                r_acc  <= {{N{1'b0}}, w_mag2};
            end
        end else if (r_state == CALC) begin
            r_acc <= r_op[2] ? w_div_next : w_mul_next;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam int N = 64;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MNEG = 64'h8000_0000_0000_0000;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [2:0]    op;
    logic [N-1:0]  src1;
    logic [N-1:0]  src2;
    logic          flush;
    logic          busy;
    logic          result_valid;
    logic [N-1:0]  result;

    muldiv_unit #(.DATA_SIZE(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .src1         (src1),
        .src2         (src2),
        .flush        (flush),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [63:0] last_exp = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    endtask

    task automatic add(input string nm, input logic [2:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] e, input int l);
        vec_t v;
        v.name = nm; v.op = o; v.a = a; v.b = b; v.exp = e; v.lat = l;
        vecs.push_back(v);
    endtask

    // Issue one op from idle, track busy every cycle, and check latency,
    // result, single-cycle strobe and result hold.
    task automatic run_vec(input vec_t v);
        int cyc;
        int vcyc;
        bit busy_ok;
        bit exp_busy;
        @(negedge clk);
        start = 1'b1; op = v.op; src1 = v.a; src2 = v.b;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; vcyc = -1; busy_ok = 1'b1;
        while (vcyc < 0 && cyc < 100) begin
            exp_busy = (v.lat > 1) && (cyc < v.lat);
            if (busy !== exp_busy) busy_ok = 1'b0;
            if (result_valid === 1'b1) vcyc = cyc;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk({v.name, " latency"}, 64'(vcyc), 64'(v.lat));
        chk({v.name, " busy"}, {63'd0, busy_ok}, 64'd1);
        chk({v.name, " result"}, result, v.exp);
        @(negedge clk);
        chk({v.name, " strobe"}, {63'd0, result_valid}, 64'd0);
        chk({v.name, " hold"}, result, v.exp);
        last_exp = v.exp;
    endtask

    initial begin : main
        int  cyc;
        bit  saw;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; src1 = '0; src2 = '0;

        add("MUL 7*-3",       3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66);
        add("MUL 0x1234*16",  3'd0, 64'h1234, 64'h10, 64'h12340, 66);
        add("MULH min*min",   3'd1, MNEG, MNEG, 64'h4000_0000_0000_0000, 66);
        add("MULHU ones",     3'd3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        add("MULHSU -1*2",    3'd2, ONES, 64'd2, ONES, 66);
        add("MULH -1*2",      3'd1, ONES, 64'd2, ONES, 66);
        add("DIVU 100/7",     3'd5, 64'd100, 64'd7, 64'd14, 66);
        add("REMU 100/7",     3'd7, 64'd100, 64'd7, 64'd2, 66);
        add("DIV -7/2",       3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        add("REM -7/2",       3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 66);
        add("REM 7/-2",       3'd6, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66);
        add("DIV 7/-2",       3'd4, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        add("DIVU ones/16",   3'd5, ONES, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 66);
        add("REMU ones/16",   3'd7, ONES, 64'h10, 64'hF, 66);
        add("DIVU min/ones",  3'd5, MNEG, ONES, 64'd0, 66);
        add("DIV 5/0",        3'd4, 64'd5, 64'd0, ONES, 1);
        add("REMU 5/0",       3'd7, 64'd5, 64'd0, 64'd5, 1);
        add("DIVU 5/0",       3'd5, 64'd5, 64'd0, ONES, 1);
        add("DIV min/-1",     3'd4, MNEG, ONES, MNEG, 1);
        add("REM min/-1",     3'd6, MNEG, ONES, 64'd0, 1);

        // Power-on reset
        repeat (2) @(negedge clk);
        chk("reset busy",   {63'd0, busy}, 64'd0);
        chk("reset valid",  {63'd0, result_valid}, 64'd0);
        chk("reset result", result, 64'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset asserted in the middle of a multiply
        @(negedge clk);
        start = 1'b1; op = 3'd0; src1 = 64'd9; src2 = 64'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre-reset busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midop reset busy",   {63'd0, busy}, 64'd0);
        chk("midop reset valid",  {63'd0, result_valid}, 64'd0);
        chk("midop reset result", result, 64'd0);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (70) begin
            if (result_valid === 1'b1) saw = 1'b1;
            @(negedge clk);
        end
        chk("midop reset no strobe", {63'd0, saw}, 64'd0);
        run_vec(vecs[6]);

        // Flush during CALC at cycle 30 of a divide
        @(negedge clk);
        start = 1'b1; op = 3'd4; src1 = 64'd1000; src2 = 64'd3;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk("flush pre busy", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy@31", {63'd0, busy}, 64'd0);
        saw = 1'b0;
        repeat (80) begin
            if (result_valid === 1'b1) saw = 1'b1;
            @(negedge clk);
        end
        chk("flush no strobe", {63'd0, saw}, 64'd0);
        chk("flush result kept", result, last_exp);

        // flush and start together: start dropped (special and normal ops)
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'd4; src1 = 64'd5; src2 = 64'd0;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush+start special valid", {63'd0, result_valid}, 64'd0);
        chk("flush+start special busy",  {63'd0, busy}, 64'd0);
        chk("flush+start special result", result, last_exp);
        start = 1'b1; flush = 1'b1; op = 3'd5; src1 = 64'd50; src2 = 64'd5;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush+start normal busy", {63'd0, busy}, 64'd0);

        // Back-to-back: second start presented in the first op's DONE cycle
        @(negedge clk);
        start = 1'b1; op = 3'd5; src1 = 64'd100; src2 = 64'd7;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (result_valid !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b first latency", 64'(cyc), 64'd66);
        chk("b2b first result", result, 64'd14);
        start = 1'b1; op = 3'd0; src1 = 64'd7; src2 = 64'hFFFF_FFFF_FFFF_FFFD;
        @(negedge clk);
        start = 1'b0;
        op = 3'd4; src1 = 64'd5; src2 = 64'd0;
        cyc = 1;
        chk("b2b second busy", {63'd0, busy}, 64'd1);
        while (result_valid !== 1'b1 && cyc < 100) begin
            start = (cyc == 5) || (cyc == 6) || (cyc == 40);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("b2b second latency", 64'(cyc), 64'd66);
        chk("b2b second result", result, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clk);
        chk("b2b no queued op valid", {63'd0, result_valid}, 64'd0);
        chk("b2b no queued op busy",  {63'd0, busy}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV64M multiply/divide sequencer in the execute stage, beside the single-cycle ALU. It accepts one M-extension operation at a time and runs a shift-add multiply or restoring divide over DATA_SIZE iterations. It then applies sign correction and presents a registered result with a one-cycle valid strobe. The hazard unit stalls the pipeline while the block is busy.

## Interface
- DATA_SIZE, default 64: operand/result width; iteration count equals DATA_SIZE.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only when busy=0.
- op  in  3  RV funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- src1  in  DATA_SIZE  rs1 operand (multiplicand / dividend).
- src2  in  DATA_SIZE  rs2 operand (multiplier / divisor).
- flush  in  1  pipeline flush; aborts the current operation.
- busy  out  1  high in CALC and FIXUP.
- result_valid  out  1  one-cycle strobe, high in DONE.
- result  out  DATA_SIZE  registered result; held until the next accepted start.

## Operation
- States: IDLE, CALC, FIXUP, DONE. Reset forces IDLE; busy=0, result_valid=0, result=0, counter=0.
- Accept: start=1 and flush=0 in IDLE or DONE. On accept, op, operand magnitudes and sign flags are latched.
  - Signed operands: MULH, DIV, REM both signed; MULHSU src1 only.
  - Counter loads DATA_SIZE-1.
- Special cases, op 4-7, decided at accept and sent straight to DONE:
  - Divisor 0: DIV/DIVU result all-ones; REM/REMU result = src1.
  - Signed overflow, DIV/REM with src1 = 1 followed by DATA_SIZE-1 zeros (most negative) and src2 = all-ones: DIV result = src1; REM result = 0.
- CALC, multiply: 2*DATA_SIZE-bit accumulator.
  - If the multiplier LSB is 1, add the multiplicand to the upper half with carry.
  - Then shift the whole accumulator right by 1.
- CALC, divide: restoring.
  - Shift {rem, quot} left by 1.
  - If rem >= divisor, subtract divisor and set quot LSB.
- CALC: one iteration per cycle. Counter decrements; the iteration done at counter=0 moves to FIXUP.
- FIXUP:
  - Multiply: negate the full 2*DATA_SIZE product if the sign flags differ.
  - Divide: quotient negated if the sign flags differ; remainder takes the dividend's sign.
  - Select MUL = low half, MULH/MULHSU/MULHU = high half, DIV(U) = quotient, REM(U) = remainder. Load result; go to DONE.
- DONE: result_valid=1 for exactly one cycle. Next state is CALC/DONE if a new start is accepted, else IDLE.
- flush=1 in any state: next state IDLE, no result_valid; result keeps its old value. flush has priority over start.
- start while busy=1 is ignored; no queueing.
- rst_n=0 mid-operation: same as reset; in-flight operation discarded.

## Timing
- Start accepted in cycle 0 (normal path):
  - CALC cycles 1..DATA_SIZE.
  - FIXUP cycle DATA_SIZE+1.
  - DONE / result_valid in cycle DATA_SIZE+2, i.e. 66 for DATA_SIZE=64.
- Special case: result_valid in cycle 1.
- busy is registered state decode; it is 0 in the accept cycle. The integrator's stall is start | busy.
- result changes only on the FIXUP→DONE edge or the special-case accept edge; it is stable while result_valid=1.
- Back-to-back: start in a DONE cycle is accepted; busy=1 the following cycle.

## Test plan
- Reset: rst_n=0 for 2 cycles during CALC -> busy=0, result_valid=0, result=0; a later start behaves normally.
- MUL: src1=7, src2=-3 -> result 0xFFFF_FFFF_FFFF_FFEB, result_valid exactly at cycle 66, busy high cycles 1-65. Also check these high-half results:
  - MULH 0x8000_0000_0000_0000 × same -> 0x4000_0000_0000_0000.
  - MULHU all-ones × all-ones -> 0xFFFF_FFFF_FFFF_FFFE.
  - MULHSU -1 × 2 -> all-ones.
- Divide signs:
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - DIV -7/2 -> -3; REM -7/2 -> -1.
  - REM 7/-2 -> 1.
- Special cases, each with result_valid at cycle 1:
  - DIV 5/0 -> all-ones; REMU 5/0 -> 5.
  - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM of the same -> 0.
- Flush:
  - flush at cycle 30 of a DIV -> busy=0 at cycle 31, no result_valid, result unchanged.
  - flush and start in the same cycle -> start ignored.
- Back-to-back: second start held high during the first op's DONE cycle -> accepted; second result_valid 66 cycles later; start pulses while busy=1 have no effect.
